// File: rtl/ibex_csr_bank_if.sv
// Decoder-side port bundle for ibex_csr_bank: one write port, one read port,
// lock request and the status flags returned to the CSR decoder.
interface ibex_csr_bank_if #(
    parameter int Width   = 32,
    parameter int NumRegs = 4
) ();
    localparam int AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    logic             wr_en_i;
    logic [AddrW-1:0] wr_addr_i;
    logic [Width-1:0] wr_data_i;
    logic             arm_i;
    logic             lock_set_i;
    logic [AddrW-1:0] rd_addr_i;
    logic [Width-1:0] rd_data_o;
    logic             rd_error_o;
    logic             wr_error_o;
    logic             err_sticky_o;
    logic             locked_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, arm_i, lock_set_i, rd_addr_i,
        input  rd_data_o, rd_error_o, wr_error_o, err_sticky_o, locked_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, arm_i, lock_set_i, rd_addr_i,
        output rd_data_o, rd_error_o, wr_error_o, err_sticky_o, locked_o
    );
endinterface

// File: rtl/ibex_csr_bank.sv
// Bank of NumRegs CSRs with write masks, armed auto-clear, sticky lock.
// Define IBEX_CSR_BANK_SHADOW_EN to build inverted shadow copies with tamper detection.
module ibex_csr_bank #(
    parameter int                         Width       = 32,
    parameter int                         NumRegs     = 4,
    parameter logic [NumRegs*Width-1:0]   ResetValue  = '0,
    parameter logic [NumRegs*Width-1:0]   WriteMask   = '1,
    parameter logic [NumRegs*Width-1:0]   AutoClrMask = '0,
    parameter logic [NumRegs-1:0]         LockMask    = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ibex_csr_bank_if.slave   bus
);
    localparam int AddrW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    typedef enum logic {
        AC_IDLE = 1'b0,
        AC_PEND = 1'b1
    } ac_state_e;

    ac_state_e                      ac_q [NumRegs];
    ac_state_e                      ac_d [NumRegs];
    logic [NumRegs-1:0][Width-1:0]  reg_q;
    logic [NumRegs-1:0][Width-1:0]  reg_d;
    logic                           lock_q;
    logic                           lock_d;
    logic                           wr_error_q;
    logic                           wr_error_d;
    logic [NumRegs-1:0]             wr_hit_s;
    logic [NumRegs-1:0]             rd_sel_s;
    logic                           rd_in_range_s;
    logic [Width-1:0]               rd_data_s;

    function automatic logic [Width-1:0] masked_merge(
        input logic [Width-1:0] old_val,
        input logic [Width-1:0] new_val,
        input logic [Width-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Write decode: out-of-range addresses never hit, so they fall through to rejection.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            wr_hit_s[i] = bus.wr_en_i && (bus.wr_addr_i == AddrW'(i)) &&
                          !(lock_q && LockMask[i]);
        end
        wr_error_d = bus.wr_en_i && (wr_hit_s == {NumRegs{1'b0}});
        lock_d     = lock_q | bus.lock_set_i;
    end

    // Per-register next value and auto-clear state; lock never blocks a pending clear.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            reg_d[i] = reg_q[i];
            ac_d[i]  = AC_IDLE;
            case (ac_q[i])
                AC_IDLE: begin
                    if (wr_hit_s[i]) begin
                        reg_d[i] = masked_merge(reg_q[i], bus.wr_data_i,
                                                WriteMask[i*Width +: Width]);
                        if (bus.arm_i && ((bus.wr_data_i & WriteMask[i*Width +: Width] &
                                           AutoClrMask[i*Width +: Width]) != {Width{1'b0}})) begin
                            ac_d[i] = AC_PEND;
                        end else begin
                            ac_d[i] = AC_IDLE;
                        end
                    end else begin
                        reg_d[i] = reg_q[i];
                    end
                end
                AC_PEND: begin
                    if (wr_hit_s[i]) begin
                        reg_d[i] = masked_merge(reg_q[i],
                                                bus.wr_data_i & ~AutoClrMask[i*Width +: Width],
                                                WriteMask[i*Width +: Width]);
                    end else begin
                        reg_d[i] = reg_q[i] & ~AutoClrMask[i*Width +: Width];
                    end
                    ac_d[i] = AC_IDLE;
                end
                default: begin
                    reg_d[i] = reg_q[i];
                    ac_d[i]  = AC_IDLE;
                end
            endcase
        end
    end

    // Register array, auto-clear state, lock and write-error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                reg_q[i] <= ResetValue[i*Width +: Width];
                ac_q[i]  <= AC_IDLE;
            end
            lock_q     <= 1'b0;
            wr_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                reg_q[i] <= reg_d[i];
                ac_q[i]  <= ac_d[i];
            end
            lock_q     <= lock_d;
            wr_error_q <= wr_error_d;
        end
    end

    // One-hot read select; an unmatched address yields zero data.
    always_comb begin
        rd_data_s = {Width{1'b0}};
        for (int i = 0; i < NumRegs; i++) begin
            rd_sel_s[i] = (bus.rd_addr_i == AddrW'(i));
            rd_data_s   = rd_data_s | ({Width{rd_sel_s[i]}} & reg_q[i]);
        end
        rd_in_range_s = |rd_sel_s;
    end

`ifdef IBEX_CSR_BANK_SHADOW_EN
    logic [NumRegs-1:0][Width-1:0]  shadow_q;
    logic [NumRegs-1:0][Width-1:0]  shadow_d;
    logic [NumRegs-1:0]             reg_upd_s;
    logic [NumRegs-1:0]             mismatch_s;
    logic                           err_sticky_q;
    logic                           err_sticky_d;

    // Shadow follows the inverted next value only when the register itself is updated.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            reg_upd_s[i]  = wr_hit_s[i] || (ac_q[i] == AC_PEND);
            shadow_d[i]   = reg_upd_s[i] ? ~reg_d[i] : shadow_q[i];
            mismatch_s[i] = (reg_q[i] != ~shadow_q[i]);
        end
        err_sticky_d = err_sticky_q | (|mismatch_s);
    end

    // Shadow storage and sticky tamper flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                shadow_q[i] <= ~ResetValue[i*Width +: Width];
            end
            err_sticky_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.rd_error_o   = !rd_in_range_s || ((rd_sel_s & mismatch_s) != {NumRegs{1'b0}});
    assign bus.err_sticky_o = err_sticky_q;
`else
    assign bus.rd_error_o   = !rd_in_range_s;
    assign bus.err_sticky_o = 1'b0;
`endif

    assign bus.rd_data_o  = rd_data_s;
    assign bus.wr_error_o = wr_error_q;
    assign bus.locked_o   = lock_q;

endmodule

// File: tb/tb_ibex_csr_bank.sv
// Scoreboard bench for ibex_csr_bank: directed plan items plus random traffic
// checked against an array-based reference model.
module tb_ibex_csr_bank;
    localparam int W = 32;
    localparam int N = 4;
    localparam logic [N*W-1:0] RV  = {32'h1234_5678, 32'h0000_0000, 32'h0000_00A5, 32'h0000_0000};
    localparam logic [N*W-1:0] WM  = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    localparam logic [N*W-1:0] ACM = {32'h0000_0F00, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000};
    localparam logic [N-1:0]   LM  = 4'b0010;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ibex_csr_bank_if #(.Width(W), .NumRegs(N)) bus ();

    ibex_csr_bank #(
        .Width(W), .NumRegs(N), .ResetValue(RV), .WriteMask(WM),
        .AutoClrMask(ACM), .LockMask(LM)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        rd_err;
        logic        wr_err;
        logic        err_st;
        logic        locked;
        bit          has_c;
        logic [31:0] c;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: register contents and which registers owe a clear next edge.
    logic [31:0] m_reg [N];
    bit          m_pend [N];
    bit          m_lock;
    bit          m_wr_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_reg[i]  = RV[i*W +: W];
            m_pend[i] = 1'b0;
        end
        m_lock   = 1'b0;
        m_wr_err = 1'b0;
    endtask

    task automatic model_update(input bit we, input int a, input logic [31:0] d,
                                input bit arm, input bit ls);
        bit          acc;
        bit          new_pend;
        logic [31:0] dd;
        logic [31:0] wm;
        logic [31:0] acm;
        acc = we && (a < N) && !(m_lock && LM[a]);
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && !(acc && a == i)) m_reg[i] = m_reg[i] & ~ACM[i*W +: W];
        end
        new_pend = 1'b0;
        if (acc) begin
            wm  = WM[a*W +: W];
            acm = ACM[a*W +: W];
            dd  = m_pend[a] ? (d & ~acm) : d;
            m_reg[a] = (m_reg[a] & ~wm) | (dd & wm);
            new_pend = !m_pend[a] && arm && ((d & wm & acm) != 32'h0);
        end
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        if (acc) m_pend[a] = new_pend;
        m_wr_err = we && !acc;
        m_lock   = m_lock | ls;
    endtask

    // Drive one cycle of inputs, queue what the outputs must show, then advance the model.
    task automatic step(input bit we, input int a, input logic [31:0] d, input bit arm,
                        input bit ls, input int ra, input bit hc, input logic [31:0] c);
        exp_t e;
        bus.wr_en_i    = we;
        bus.wr_addr_i  = 2'(a);
        bus.wr_data_i  = d;
        bus.arm_i      = arm;
        bus.lock_set_i = ls;
        bus.rd_addr_i  = 2'(ra);
        e.rd     = m_reg[ra];
        e.rd_err = 1'b0;
        e.wr_err = m_wr_err;
        e.err_st = 1'b0;
        e.locked = m_lock;
        e.has_c  = hc;
        e.c      = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        model_update(we, a, d, arm, ls);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", bus.rd_data_o, e.rd);
                chk("rd_error", {31'h0, bus.rd_error_o}, {31'h0, e.rd_err});
                chk("wr_error", {31'h0, bus.wr_error_o}, {31'h0, e.wr_err});
                chk("err_sticky", {31'h0, bus.err_sticky_o}, {31'h0, e.err_st});
                chk("locked", {31'h0, bus.locked_o}, {31'h0, e.locked});
                if (e.has_c) chk("plan_rd", bus.rd_data_o, e.c);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        bus.wr_en_i = 1'b0; bus.wr_addr_i = 2'd0; bus.wr_data_i = 32'h0;
        bus.arm_i = 1'b0; bus.lock_set_i = 1'b0; bus.rd_addr_i = 2'd0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset contents and masked write
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 32'h0000_00A5);
        step(1'b1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0000);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_BEEF);
        // Armed auto-clear, then unarmed
        step(1'b1, 2, 32'h30, 1'b1, 1'b0, 2, 1'b0, 32'h0);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h30);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h10);
        step(1'b1, 2, 32'h30, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h30);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h30);
        // Write while pending: clear bits masked, no re-arm
        step(1'b1, 2, 32'h30, 1'b1, 1'b0, 2, 1'b0, 32'h0);
        step(1'b1, 2, 32'h3F, 1'b1, 1'b0, 2, 1'b1, 32'h30);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h1F);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h1F);
        // Write coincident with lock request uses the old lock, later writes rejected
        step(1'b1, 1, 32'h5A, 1'b0, 1'b1, 1, 1'b1, 32'h0000_00A5);
        step(1'b1, 1, 32'hFF, 1'b0, 1'b0, 1, 1'b1, 32'h0000_005A);
        step(1'b1, 0, 32'h1234, 1'b0, 1'b0, 1, 1'b1, 32'h0000_005A);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_1234);

        // Reset while a clear is pending
        step(1'b1, 2, 32'h20, 1'b1, 1'b0, 2, 1'b0, 32'h0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h0);
        step(1'b0, 0, 32'h0, 1'b0, 1'b0, 2, 1'b1, 32'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4095)) : $urandom();
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), d,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0),
                 int'($urandom_range(0, N - 1)), 1'b0, 32'h0);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'h0);

`ifdef IBEX_CSR_BANK_SHADOW_EN
        begin
            logic b0;
            bus.wr_en_i = 1'b0;
            bus.lock_set_i = 1'b0;
            bus.rd_addr_i = 2'd3;
            @(posedge clk);
            #1;
            b0 = m_reg[3][0];
            force dut.reg_q[3][0] = ~b0;
            #1;
            chk("tamper_rd_error", {31'h0, bus.rd_error_o}, 32'h1);
            chk("tamper_sticky_pre", {31'h0, bus.err_sticky_o}, 32'h0);
            @(posedge clk);
            #1;
            release dut.reg_q[3][0];
            chk("tamper_sticky", {31'h0, bus.err_sticky_o}, 32'h1);
            repeat (3) @(posedge clk);
            #1;
            chk("tamper_sticky_held", {31'h0, bus.err_sticky_o}, 32'h1);
            rst = 1'b1;
            #2;
            rst = 1'b0;
            #1;
            chk("tamper_sticky_reset", {31'h0, bus.err_sticky_o}, 32'h0);
            chk("tamper_rd_error_reset", {31'h0, bus.rd_error_o}, 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ibex_csr_bank.md
# ibex_csr_bank

Parametrised bank of NumRegs control/status registers for the Ibex core's CSR file: per-register write masks, armed auto-clear bits, a sticky write lock, and optional inverted shadow copies with tamper/fault detection. Sits between the CSR decoder (one write port, one read port) and the consuming logic. Replaces per-register CSR primitives where several related registers share one decoded port.

## Interface
- Width, 32: bits per register.
- NumRegs, 4: number of registers (≥1); AddrW = max(1, $clog2(NumRegs)).
- ResetValue, '0: NumRegs×Width packed; reset contents, register i at slice i.
- WriteMask, '1: NumRegs×Width packed; 1 = software-writable bit.
- AutoClrMask, '0: NumRegs×Width packed; bits cleared one cycle after an armed write sets them.
- LockMask, '0: NumRegs bits; 1 = register frozen once lock is set.

- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous and active-high.
- wr_en_i  in  1  write strobe.
- wr_addr_i  in  AddrW  write register index.
- wr_data_i  in  Width  write data.
- arm_i  in  1  enables auto-clear arming for the current write.
- lock_set_i  in  1  sets sticky lock.
- rd_addr_i  in  AddrW  read register index.
- rd_data_o  out  Width  read data (combinational).
- rd_error_o  out  1  addressed register bad (shadow mismatch or out-of-range).
- wr_error_o  out  1  registered pulse: previous-cycle write rejected.
- err_sticky_o  out  1  any shadow mismatch seen since reset.
- locked_o  out  1  lock state.

## Operation
- Reset: reg[i] = ResetValue[i], shadow[i] = ~ResetValue[i], pend[i] = 0, lock = 0, wr_error_o = 0, err_sticky_o = 0.
- Accepted write (wr_en_i, wr_addr_i < NumRegs, not (lock && LockMask[a])): reg[a] <= (reg[a] & ~WM) | (d & WM), with d = wr_data_i.
- Rejected write (address out of range or locked register): no state change; wr_error_o = 1 next cycle only.
- Auto-clear, per register, two states IDLE/PEND:
  - IDLE→PEND: accepted write with arm_i = 1 and (wr_data_i & WM & ACM) != 0.
  - PEND→IDLE unconditionally next cycle; if no accepted write to that register: reg <= reg & ~ACM.
  - PEND plus accepted write to same register: write applies with d & ~ACM; no re-arm regardless of arm_i.
- Lock: lock_set_i sets lock next edge; cleared only by reset. Lock does not cancel a PEND clear already in flight.
- Read: rd_data_o = reg[rd_addr_i]; out of range -> 0 with rd_error_o = 1.
- Shadow: shadow[i] <= ~next value of reg[i] on every reg update, including auto-clear. rd_error_o = (reg[rd_addr_i] != ~shadow[rd_addr_i]).
- err_sticky_o: set next edge when any register mismatches; held until reset.

## Timing
- Write to read-back: 1 cycle; auto-clear visible 2 cycles after the armed write edge.
- wr_error_o, err_sticky_o, locked_o registered; rd_data_o, rd_error_o combinational from rd_addr_i.
- Simultaneous lock_set_i and write: write evaluated against old lock (accepted).
- Reset asserted mid-PEND: pending clear discarded, ResetValue restored.

## Configuration
- IBEX_CSR_BANK_SHADOW_EN defined: shadow registers built as above.
- Undefined: no shadow storage; rd_error_o reflects only out-of-range reads; err_sticky_o tied 0.

## Test plan
- Reset, ResetValue reg1 = 0x0000_00A5: read addr1 -> 0x0000_00A5, all error outputs 0.
- WriteMask reg0 = 0x0000_FFFF, write 0xDEAD_BEEF -> read 0x0000_BEEF next cycle.
- ACM reg2 = 0x20, arm_i = 1, write 0x30 -> read 0x30 cycle+1, 0x10 cycle+2; same with arm_i = 0 -> 0x30 stays.
- Armed write 0x30 to reg2, then write 0x3F next cycle -> read 0x1F, no further clear.
- LockMask = 4'b0010, pulse lock_set_i, write addr1 0xFF -> unchanged, wr_error_o pulses 1 cycle; write addr0 accepted.
- SHADOW_EN: force-flip reg3 bit 0 -> rd_error_o = 1 at addr3, err_sticky_o = 1 next cycle and held until rst_i.
